// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'd0,
    UNIT_LOGIC = 2'd1,
    UNIT_CMP   = 2'd2,
    UNIT_SHIFT = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [3:0] FUN_DIV = 4'b0011;

  // One-hot enable pattern, bit order {shift, cmp, logic, arith}.
  function automatic logic [3:0] unit_onehot(input unit_e sel);
    unit_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle between a requester and the sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned OUT_WIDTH = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_fun;
  logic [A_WIDTH-1:0]   cmd_a;
  logic [B_WIDTH-1:0]   cmd_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_WIDTH-1:0] rsp_data;
  logic                 rsp_carry;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_result_mux.sv
// Combinational selection of the active unit's result and completion flag.
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 16
) (
  input  unit_e                sel,
  input  logic [OUT_WIDTH-1:0] arith_out,
  input  logic [OUT_WIDTH-1:0] logic_out,
  input  logic [OUT_WIDTH-1:0] cmp_out,
  input  logic [OUT_WIDTH-1:0] shift_out,
  input  logic                 arith_flag,
  input  logic                 logic_flag,
  input  logic                 cmp_flag,
  input  logic                 shift_flag,
  output logic [OUT_WIDTH-1:0] data_c,
  output logic                 flag_c
);

  always_comb begin
    data_c = '0;
    flag_c = 1'b0;
    case (sel)
      UNIT_ARITH: begin data_c = arith_out; flag_c = arith_flag; end
      UNIT_LOGIC: begin data_c = logic_out; flag_c = logic_flag; end
      UNIT_CMP:   begin data_c = cmp_out;   flag_c = cmp_flag;   end
      UNIT_SHIFT: begin data_c = shift_out; flag_c = shift_flag; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to the selected ALU unit and returns its result,
// trapping divide-by-zero and bounding the wait with a watchdog.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned A_WIDTH        = 16,
  parameter int unsigned B_WIDTH        = 16,
  parameter int unsigned OUT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.slave    bus,
  output logic [A_WIDTH-1:0]   A_OUT,
  output logic [B_WIDTH-1:0]   B_OUT,
  output logic [3:0]           ALU_FUN,
  output logic                 Arith_Enable,
  output logic                 Logic_Enable,
  output logic                 CMP_Enable,
  output logic                 SHIFT_Enable,
  input  logic [OUT_WIDTH-1:0] arith_out,
  input  logic [OUT_WIDTH-1:0] logic_out,
  input  logic [OUT_WIDTH-1:0] cmp_out,
  input  logic [OUT_WIDTH-1:0] shift_out,
  input  logic                 arith_flag,
  input  logic                 logic_flag,
  input  logic                 cmp_flag,
  input  logic                 shift_flag,
  input  logic                 arith_carry
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_RESP  = RESP;

  logic [1:0]           state, state_nx;
  unit_e                sel, sel_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [3:0]           en, en_nx;
  logic [A_WIDTH-1:0]   a_nx;
  logic [B_WIDTH-1:0]   b_nx;
  logic [3:0]           fun_nx;
  logic [OUT_WIDTH-1:0] data_nx;
  logic                 carry_nx, err_nx, ready_nx, valid_nx;
  logic [OUT_WIDTH-1:0] mux_data_c;
  logic                 mux_flag_c;

  alu_result_mux #(.OUT_WIDTH(OUT_WIDTH)) u_mux (
    .sel        (sel),
    .arith_out  (arith_out),
    .logic_out  (logic_out),
    .cmp_out    (cmp_out),
    .shift_out  (shift_out),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag),
    .data_c     (mux_data_c),
    .flag_c     (mux_flag_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    cnt_nx   = cnt;
    a_nx     = A_OUT;
    b_nx     = B_OUT;
    fun_nx   = ALU_FUN;
    data_nx  = bus.rsp_data;
    carry_nx = bus.rsp_carry;
    err_nx   = bus.rsp_err;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          a_nx   = bus.cmd_a;
          b_nx   = bus.cmd_b;
          fun_nx = bus.cmd_fun;
          sel_nx = unit_e'(bus.cmd_fun[3:2]);
          if (bus.cmd_fun == FUN_DIV && bus.cmd_b == '0) begin
            data_nx  = '0;
            carry_nx = 1'b0;
            err_nx   = 1'b1;
            state_nx = S_RESP;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_nx   = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mux_flag_c) begin
          data_nx  = mux_data_c;
          carry_nx = (sel == UNIT_ARITH) ? arith_carry : 1'b0;
          err_nx   = 1'b0;
          state_nx = S_RESP;
        end else begin
          if (cnt != CNT_MAX) cnt_nx = cnt + CNT_W'(1);
          if (cnt_nx == CNT_MAX) begin
            data_nx  = '0;
            carry_nx = 1'b0;
            err_nx   = 1'b1;
            state_nx = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          data_nx  = '0;
          carry_nx = 1'b0;
          err_nx   = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    ready_nx = (state_nx == S_IDLE);
    valid_nx = (state_nx == S_RESP);
    en_nx    = (state_nx == S_ISSUE || state_nx == S_WAIT) ? unit_onehot(sel_nx) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      sel           <= UNIT_ARITH;
      cnt           <= '0;
      en            <= '0;
      A_OUT         <= '0;
      B_OUT         <= '0;
      ALU_FUN       <= '0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state         <= state_nx;
      sel           <= sel_nx;
      cnt           <= cnt_nx;
      en            <= en_nx;
      A_OUT         <= a_nx;
      B_OUT         <= b_nx;
      ALU_FUN       <= fun_nx;
      bus.cmd_ready <= ready_nx;
      bus.rsp_valid <= valid_nx;
      bus.rsp_data  <= data_nx;
      bus.rsp_carry <= carry_nx;
      bus.rsp_err   <= err_nx;
    end
  end

  assign Arith_Enable = en[0];
  assign Logic_Enable = en[1];
  assign CMP_Enable   = en[2];
  assign SHIFT_Enable = en[3];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with simple behavioural ALU unit models.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(16)) bus ();

  logic [15:0] A_OUT, B_OUT;
  logic [3:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag, arith_carry;

  logic [3:0] stuck = 4'b0000;
  logic       logic_force = 1'b0;
  logic [3:0] en;
  assign en = {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

  int n_cmp  = 0;
  int n_fail = 0;

  alu_op_sequencer #(.A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .A_OUT(A_OUT), .B_OUT(B_OUT), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag),
    .shift_flag(shift_flag), .arith_carry(arith_carry)
  );

  // Compliant units: flag and result appear the cycle after the enable edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      {arith_carry, arith_out} <= 17'd0;
      logic_out  <= 16'd0;
      cmp_out    <= 16'd0;
      shift_out  <= 16'd0;
      arith_flag <= 1'b0;
      logic_flag <= 1'b0;
      cmp_flag   <= 1'b0;
      shift_flag <= 1'b0;
    end else begin
      {arith_carry, arith_out} <= (ALU_FUN == 4'b0001) ? ({1'b0, A_OUT} - {1'b0, B_OUT})
                                                       : ({1'b0, A_OUT} + {1'b0, B_OUT});
      logic_out  <= ALU_FUN[0] ? (A_OUT | B_OUT) : (A_OUT & B_OUT);
      cmp_out    <= {15'd0, A_OUT == B_OUT};
      shift_out  <= A_OUT >> 1;
      arith_flag <= Arith_Enable & ~stuck[0];
      logic_flag <= (Logic_Enable & ~stuck[1]) | logic_force;
      cmp_flag   <= CMP_Enable & ~stuck[2];
      shift_flag <= SHIFT_Enable & ~stuck[3];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command during cycle 0; returns at cycle 1 with cmd_valid dropped.
  task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    bus.cmd_fun   = f;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_cmp++; if (en !== 4'b0000) begin n_fail++; $display("FAIL reset_enables got %b want 0000", en); end
    n_cmp++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_carry} !== 18'd0) begin n_fail++; $display("FAIL reset_rsp got %h/%b/%b want 0", bus.rsp_data, bus.rsp_err, bus.rsp_carry); end
    n_cmp++; if ({A_OUT, B_OUT, ALU_FUN} !== 36'd0) begin n_fail++; $display("FAIL reset_operands got %h %h %h want 0", A_OUT, B_OUT, ALU_FUN); end
    @(posedge clk);
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_add();
    bus.rsp_ready = 1'b1;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL add_c0_ready got %b want 1", bus.cmd_ready); end
    send(4'b0000, 16'd5, 16'd3);
    n_cmp++; if (en !== 4'b0001) begin n_fail++; $display("FAIL add_c1_enable got %b want 0001", en); end
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL add_c1_ready got %b want 0", bus.cmd_ready); end
    n_cmp++; if ({A_OUT, B_OUT, ALU_FUN} !== {16'd5, 16'd3, 4'b0000}) begin n_fail++; $display("FAIL add_c1_operands got %h %h %h want 5 3 0", A_OUT, B_OUT, ALU_FUN); end
    step();
    n_cmp++; if (en !== 4'b0001 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_c2 got en %b valid %b want 0001 0", en, bus.rsp_valid); end
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b1 || en !== 4'b0000) begin n_fail++; $display("FAIL add_c3_valid got valid %b en %b want 1 0000", bus.rsp_valid, en); end
    n_cmp++; if (bus.rsp_data !== 16'd8 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL add_c3_data got %h err %b want 0008 0", bus.rsp_data, bus.rsp_err); end
    step();
    n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_c4 got ready %b valid %b want 1 0", bus.cmd_ready, bus.rsp_valid); end
  endtask

  task automatic test_div_zero();
    bus.rsp_ready = 1'b1;
    send(4'b0011, 16'd100, 16'd0);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL div0_c1 got valid %b err %b want 1 1", bus.rsp_valid, bus.rsp_err); end
    n_cmp++; if (bus.rsp_data !== 16'd0 || en !== 4'b0000) begin n_fail++; $display("FAIL div0_c1_data got %h en %b want 0000 0000", bus.rsp_data, en); end
    step();
    n_cmp++; if (en !== 4'b0000 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL div0_c2 got en %b ready %b valid %b want 0000 1 0", en, bus.cmd_ready, bus.rsp_valid); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    send(4'b0100, 16'h00F0, 16'h0FF0);
    step();
    step();
    bus.cmd_fun = 4'b0000; bus.cmd_a = 16'h0001; bus.cmd_b = 16'h0001; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, en} !== 6'b10_0000 || bus.rsp_data !== 16'h00F0) begin
        n_fail++; $display("FAIL bp_hold_%0d got valid %b ready %b en %b data %h want 1 0 0000 00f0", i, bus.rsp_valid, bus.cmd_ready, en, bus.rsp_data);
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h00F0) begin n_fail++; $display("FAIL bp_release got valid %b data %h want 1 00f0", bus.rsp_valid, bus.rsp_data); end
    step();
    n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, en} !== 6'b01_0000) begin n_fail++; $display("FAIL bp_after got valid %b ready %b en %b want 0 1 0000", bus.rsp_valid, bus.cmd_ready, en); end
  endtask

  task automatic test_timeout();
    int en_cycles = 0;
    int resp_cyc  = 0;
    logic [15:0] d = 16'hDEAD;
    logic e = 1'b0;
    logic lg = 1'b0;
    bus.rsp_ready = 1'b1;
    stuck = 4'b1000;
    logic_force = 1'b1;
    send(4'b1100, 16'h0080, 16'h0000);
    for (int c = 1; c <= 20; c++) begin
      if (SHIFT_Enable) en_cycles++;
      if (Logic_Enable) lg = 1'b1;
      if (bus.rsp_valid) begin resp_cyc = c; d = bus.rsp_data; e = bus.rsp_err; break; end
      step();
    end
    n_cmp++; if (resp_cyc !== 10) begin n_fail++; $display("FAIL to_resp_cycle got %0d want 10", resp_cyc); end
    n_cmp++; if (en_cycles !== 9) begin n_fail++; $display("FAIL to_enable_cycles got %0d want 9", en_cycles); end
    n_cmp++; if (d !== 16'd0 || e !== 1'b1) begin n_fail++; $display("FAIL to_rsp got data %h err %b want 0000 1", d, e); end
    n_cmp++; if (lg !== 1'b0) begin n_fail++; $display("FAIL to_logic_enable got %b want 0", lg); end
    stuck = 4'b0000;
    logic_force = 1'b0;
    step();
    n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_after got ready %b valid %b want 1 0", bus.cmd_ready, bus.rsp_valid); end
  endtask

  task automatic test_reset_mid_wait();
    bus.rsp_ready = 1'b1;
    stuck = 4'b0100;
    send(4'b1000, 16'd7, 16'd7);
    step();
    n_cmp++; if (en !== 4'b0100) begin n_fail++; $display("FAIL rmw_wait_enable got %b want 0100", en); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, en} !== 6'b01_0000) begin n_fail++; $display("FAIL rmw_in_reset got valid %b ready %b en %b want 0 1 0000", bus.rsp_valid, bus.cmd_ready, en); end
    stuck = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({bus.rsp_valid, bus.cmd_ready, en} !== 6'b01_0000) begin n_fail++; $display("FAIL rmw_after_%0d got valid %b ready %b en %b want 0 1 0000", i, bus.rsp_valid, bus.cmd_ready, en); end
      step();
    end
  endtask

  task automatic test_carry();
    bus.rsp_ready = 1'b1;
    send(4'b0000, 16'hFFFF, 16'h0001);
    step();
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0000 || bus.rsp_carry !== 1'b1) begin n_fail++; $display("FAIL carry_add got valid %b data %h carry %b want 1 0000 1", bus.rsp_valid, bus.rsp_data, bus.rsp_carry); end
    step();
    send(4'b0101, 16'h1200, 16'h0034);
    step();
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1234 || bus.rsp_carry !== 1'b0) begin n_fail++; $display("FAIL carry_logic got valid %b data %h carry %b want 1 1234 0", bus.rsp_valid, bus.rsp_data, bus.rsp_carry); end
    step();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_fun   = 4'b0000;
    bus.cmd_a     = 16'd0;
    bus.cmd_b     = 16'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_div_zero();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_carry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
